instr_fetch_stage: RTL and testbench

- Front end of the 5-stage RISCV pipeline; produces the instruction/PC stream that instruction decode consumes.
- Issues in-order word requests to instruction memory over a req/gnt/rvalid handshake and buffers responses in a small FIFO.
- Presents one registered instruction per cycle to decode; honours decode stall and the jump redirect (flush) from EX.

---
 rtl/instr_fetch_stage_pkg.sv | 24 ++
 rtl/instr_fetch_stage_if.sv | 20 ++
 rtl/instr_fetch_stage_fetch_buffer.sv | 54 +++++
 rtl/instr_fetch_stage.sv | 111 +++++++++++
 tb/tb_instr_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// instr_fetch_stage_pkg: shared types and constants for the fetch stage
package instr_fetch_stage_pkg;

   typedef enum logic [1:0] {
      PC4_PC_MUX,
      BRANCH_PC_MUX,
      FLUSH_PC_MUX,
      BOOT_PC_MUX
   } pc_mux;

   typedef enum logic [1:0] {
      FETCH_BOOT,
      FETCH_RUN,
      FETCH_DRAIN
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: instruction-memory req/gnt/rvalid bus
interface instr_fetch_stage_if;

   logic        imem_req_op;
   logic [31:0] imem_addr_op;
   logic        imem_gnt_ip;
   logic        imem_rvalid_ip;
   logic [31:0] imem_rdata_ip;

   modport master (
      output imem_req_op, imem_addr_op,
      input  imem_gnt_ip, imem_rvalid_ip, imem_rdata_ip
   );

   modport slave (
      input  imem_req_op, imem_addr_op,
      output imem_gnt_ip, imem_rvalid_ip, imem_rdata_ip
   );

endinterface

// File: rtl/instr_fetch_stage_fetch_buffer.sv
// fetch_buffer: small FIFO of {instr, pc} fetch responses
module fetch_buffer
   import instr_fetch_stage_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic                                 clear,
   input  fetch_entry_t                         din,
   output logic                                 full,
   output logic                                 empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
   output fetch_entry_t                         head
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_entry_t    mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic            do_push, do_pop;

   assign empty   = count == '0;
   assign full    = count == CW'(FIFO_DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(do_pop);
         wr_ptr <= wr_ptr + AW'(do_push);
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage needs no reset; it is only read when count says it is valid
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: in-order instruction fetch with response buffer and IF/ID register
module instr_fetch_stage
   import instr_fetch_stage_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   instr_fetch_stage_if.master        imem,
   input  logic                       stall_ip,
   input  logic                       flush_en_ip,
   input  pc_mux                      pc_mux_ip,
   input  logic [31:0]                pc_branch_target_ip,
   output logic                       instr_data_valid_op,
   output logic [31:0]                instr_data_op,
   output logic [31:0]                pc_op,
   output logic [31:0]                pc4_op
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [1:0] S_BOOT  = FETCH_BOOT;
   localparam logic [1:0] S_RUN   = FETCH_RUN;
   localparam logic [1:0] S_DRAIN = FETCH_DRAIN;

   logic [1:0]    state;
   logic [31:0]   pc, tag_pc, target;
   logic [CW-1:0] outstanding, discard, discard_next, count;
   logic          redirect, accept, keep, bypass, push, pop, full, empty;
   fetch_entry_t  head;

   assign target   = {pc_branch_target_ip[31:2], 2'b00};
   assign redirect = flush_en_ip & (pc_mux_ip == FLUSH_PC_MUX);

   // in-flight plus buffered words never exceed the buffer depth, so pushes cannot overflow
   assign imem.imem_req_op  = (state != S_BOOT) & ~redirect &
                              (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH));
   assign imem.imem_addr_op = pc;
   assign accept = imem.imem_req_op & imem.imem_gnt_ip;

   assign keep   = imem.imem_rvalid_ip & ~redirect & (discard == '0);
   assign bypass = keep & ~stall_ip & empty;
   assign push   = keep & ~bypass;
   assign pop    = ~redirect & ~stall_ip & ~empty;

   assign discard_next = redirect ? outstanding - CW'(imem.imem_rvalid_ip) :
                         (imem.imem_rvalid_ip && discard != '0) ? discard - CW'(1) : discard;

   assign pc4_op = pc_op + 32'd4;

   fetch_buffer #(.FIFO_DEPTH(FIFO_DEPTH)) u_buf (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (redirect),
      .din   ({imem.imem_rdata_ip, tag_pc}),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   // a push into a full buffer without a simultaneous pop would lose a word
   assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));

   // sequencing state, fetch PC, response tag PC and in-flight bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_BOOT;
         pc          <= BOOT_ADDR;
         tag_pc      <= BOOT_ADDR;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         state       <= (state == S_BOOT) ? S_RUN :
                        (redirect && discard_next != '0) ? S_DRAIN :
                        (discard_next == '0) ? S_RUN : state;
         pc          <= redirect ? target : accept ? pc + 32'd4 : pc;
         tag_pc      <= redirect ? target : keep ? tag_pc + 32'd4 : tag_pc;
         outstanding <= outstanding + CW'(accept) - CW'(imem.imem_rvalid_ip);
         discard     <= discard_next;
      end
   end

   // IF/ID register: redirect kills it, otherwise buffered words win over the bypass
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr_data_valid_op <= 1'b0;
         instr_data_op       <= NOP_INSTR;
         pc_op               <= '0;
      end else if (redirect) begin
         instr_data_valid_op <= 1'b0;
         instr_data_op       <= NOP_INSTR;
      end else if (!stall_ip) begin
         if (!empty) begin
            instr_data_valid_op <= 1'b1;
            instr_data_op       <= head.instr;
            pc_op               <= head.pc;
         end else if (keep) begin
            instr_data_valid_op <= 1'b1;
            instr_data_op       <= imem.imem_rdata_ip;
            pc_op               <= tag_pc;
         end else begin
            instr_data_valid_op <= 1'b0;
            instr_data_op       <= NOP_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: randomized memory/decode environment with a program-order reference model
module tb_instr_fetch_stage;
   import instr_fetch_stage_pkg::*;

   localparam logic [31:0] BOOT = 32'h0000_0000;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall_ip = 1'b0;
   logic        flush_en_ip = 1'b0;
   pc_mux       pc_mux_ip = PC4_PC_MUX;
   logic [31:0] pc_branch_target_ip = '0;
   logic        instr_data_valid_op;
   logic [31:0] instr_data_op, pc_op, pc4_op;

   instr_fetch_stage_if bus ();

   instr_fetch_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
      .clock               (clock),
      .reset               (reset),
      .imem                (bus.master),
      .stall_ip            (stall_ip),
      .flush_en_ip         (flush_en_ip),
      .pc_mux_ip           (pc_mux_ip),
      .pc_branch_target_ip (pc_branch_target_ip),
      .instr_data_valid_op (instr_data_valid_op),
      .instr_data_op       (instr_data_op),
      .pc_op               (pc_op),
      .pc4_op              (pc4_op)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   rsp_t        pend[$];
   int          checks = 0, failures = 0;
   int          since_reset, first_valid_at, nvalid;
   logic [31:0] exp_fetch, exp_out, prev_addr, prev_i, prev_p;
   logic        prev_wait, prev_v;

   // memory image: every word address holds a distinct, non-NOP pattern
   function automatic logic [31:0] mw(input logic [31:0] a);
      return (a * 32'h0019_660D) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      exp_fetch      = BOOT;
      exp_out        = BOOT;
      since_reset    = 0;
      first_valid_at = -1;
      prev_wait      = 1'b0;
   endtask

   // one cycle per iteration: drive at posedge+1, check bus at posedge+2, check IF/ID after the edge
   task automatic run(input int n, input int pg, input int maxlat, input int ps, input int pf);
      for (int i = 0; i < n; i++) begin
         logic        redirect;
         logic [31:0] tgt;
         stall_ip            = $urandom_range(99) < ps;
         flush_en_ip         = $urandom_range(99) < pf;
         pc_mux_ip           = pc_mux'($urandom_range(3));
         pc_branch_target_ip = 32'($urandom_range(32'h0000_FFFF));
         redirect            = flush_en_ip && pc_mux_ip == FLUSH_PC_MUX;
         tgt                 = pc_branch_target_ip & ~32'd3;
         bus.imem_gnt_ip     = $urandom_range(99) < pg;
         if (pend.size() > 0 && pend[0].due <= since_reset) begin
            bus.imem_rvalid_ip = 1'b1;
            bus.imem_rdata_ip  = mw(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            bus.imem_rvalid_ip = 1'b0;
            bus.imem_rdata_ip  = $urandom;
         end
         #1;
         chk("addr_aligned", {30'b0, bus.imem_addr_op[1:0]}, 32'd0);
         if (since_reset == 0) chk("boot_no_req", 32'(bus.imem_req_op), 32'd0);
         if (redirect) chk("req_low_on_redirect", 32'(bus.imem_req_op), 32'd0);
         if (prev_wait && !redirect) begin
            chk("req_held", 32'(bus.imem_req_op), 32'd1);
            chk("addr_held", bus.imem_addr_op, prev_addr);
         end
         if (bus.imem_req_op && bus.imem_gnt_ip) begin
            chk("fetch_addr", bus.imem_addr_op, exp_fetch);
            pend.push_back('{addr: bus.imem_addr_op, due: since_reset + int'($urandom_range(maxlat, 1))});
            exp_fetch += 32'd4;
         end
         if (redirect) exp_fetch = tgt;
         prev_wait = bus.imem_req_op & ~bus.imem_gnt_ip;
         prev_addr = bus.imem_addr_op;
         prev_v    = instr_data_valid_op;
         prev_i    = instr_data_op;
         prev_p    = pc_op;
         @(posedge clock);
         #1;
         since_reset++;
         chk("pc4", pc4_op, pc_op + 32'd4);
         if (redirect) begin
            chk("flush_valid", 32'(instr_data_valid_op), 32'd0);
            chk("flush_instr", instr_data_op, NOP);
            exp_out = tgt;
         end else if (stall_ip) begin
            chk("stall_valid", 32'(instr_data_valid_op), 32'(prev_v));
            chk("stall_instr", instr_data_op, prev_i);
            chk("stall_pc", pc_op, prev_p);
         end else if (instr_data_valid_op) begin
            chk("out_pc", pc_op, exp_out);
            chk("out_instr", instr_data_op, mw(pc_op));
            exp_out += 32'd4;
            nvalid++;
            if (first_valid_at < 0) first_valid_at = since_reset;
         end else begin
            chk("bubble_instr", instr_data_op, NOP);
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(instr_data_valid_op), 32'd0);
      chk({tag, "_instr"}, instr_data_op, NOP);
      chk({tag, "_pc"}, pc_op, 32'd0);
      chk({tag, "_req"}, 32'(bus.imem_req_op), 32'd0);
      chk({tag, "_addr"}, bus.imem_addr_op, BOOT);
   endtask

   initial begin
      int n0;
      bus.imem_gnt_ip    = 1'b0;
      bus.imem_rvalid_ip = 1'b0;
      bus.imem_rdata_ip  = '0;
      nvalid = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b0;
      model_reset();
      n0 = nvalid;
      run(10, 100, 1, 0, 0);
      chk("first_valid_cycle", 32'(first_valid_at), 32'd3);
      chk("full_rate_count", 32'(nvalid - n0), 32'd8);
      run(40, 100, 1, 40, 0);
      run(400, 60, 4, 20, 6);
      chk("progress", 32'(nvalid > 100), 32'd1);
      run(6, 100, 3, 0, 0);
      reset = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      bus.imem_gnt_ip    = 1'b0;
      bus.imem_rvalid_ip = 1'b0;
      flush_en_ip        = 1'b0;
      stall_ip           = 1'b0;
      @(posedge clock);
      #1;
      chk_reset_outputs("midreset_hold");
      reset = 1'b0;
      model_reset();
      n0 = nvalid;
      run(10, 100, 1, 0, 0);
      chk("restart_first_valid", 32'(first_valid_at), 32'd3);
      chk("restart_count", 32'(nvalid - n0), 32'd8);
      run(300, 50, 3, 30, 10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
